rc_pkt_sequencer: RTL
=====================

Name: rc_pkt_sequencer

Overview:
- Receive-side transaction sequencer that drives the USB receive decoder (rc_dpdm).
- Arms the decoder for a DATA or handshake packet and watches SYNC detection, EOP errors and the downstream packet result.
- Enforces turnaround and packet watchdogs, aborts the decoder on failure and requests retransmission up to a retry limit.
- Sits between the protocol FSM (start/kind in, done/status out) and the decoder plus transmit side (retry request).

Parameters:
- TO_CYCLES, 255: cycles to wait for got_sync after arming before declaring timeout.
- PKT_CYCLES, 255: maximum cycles from got_sync to pkt_done before declaring packet timeout.
- MAX_RETRY, 3: maximum retransmission requests per transaction.
- TW, 8: timer width; must satisfy TO_CYCLES, PKT_CYCLES < 2^TW.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a receive transaction; sampled only in IDLE.
- kind  in  1  0 = expect DATA packet, 1 = expect handshake; latched with start.
- got_sync  in  1  decoder found SYNC.
- EOP_error  in  1  decoder EOP/bit error.
- pkt_done  in  1  downstream (nrzi/unstuff/CRC) packet complete pulse.
- pkt_ok  in  1  CRC/PID check result, valid with pkt_done.
- receive_data  out  1  arm decoder for DATA; held high while armed.
- receive_hshake  out  1  arm decoder for handshake; held high while armed.
- abort  out  1  synchronous reset pulse to decoder.
- retry  out  1  one-cycle retransmission request to transmit side.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle transaction-complete pulse.
- status  out  2  00 ok, 01 sync/pkt timeout, 10 EOP error, 11 CRC error; valid with done, held until next done.
- retry_cnt  out  2  retries issued in current transaction.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; timer, retry_cnt, latched kind, status cleared. Reset mid-transaction discards everything with no done pulse.
- States: IDLE, WAIT_SYNC, RECV, ABORT, RETRY, DONE.
- Arming: receive_data = armed & ~kind_q; receive_hshake = armed & kind_q. Armed = WAIT_SYNC or RECV. Both are never high together.
- IDLE:
  - start=1: latch kind, clear timer and retry_cnt, go to WAIT_SYNC next cycle. Arming is therefore visible 1 cycle after start.
  - start is ignored in all states other than IDLE.
- WAIT_SYNC:
  - timer increments each cycle.
  - got_sync=1: clear timer, go to RECV.
  - Else if timer == TO_CYCLES-1: cause = timeout, go to ABORT.
  - got_sync wins over a simultaneous timeout.
- RECV:
  - Priority 1: EOP_error=1 → cause EOP, go to ABORT.
  - Priority 2: pkt_done & pkt_ok → status 00, go to DONE.
  - Priority 3: pkt_done & ~pkt_ok → cause CRC, go to ABORT.
  - Priority 4: timer == PKT_CYCLES-1 → cause timeout, go to ABORT.
  - Otherwise timer increments.
- ABORT:
  - abort=1 for exactly one cycle; receive_* are 0.
  - retry_cnt < MAX_RETRY → RETRY; else status = cause, go to DONE.
- RETRY:
  - retry=1 for one cycle; retry_cnt increments; clear timer, go to WAIT_SYNC.
- DONE:
  - done=1 for one cycle, status updated in the same cycle; go to IDLE.
  - A start in the DONE cycle is ignored.
- Latency:
  - Error to abort pulse: 1 cycle.
  - Failed attempt to re-armed: 3 cycles (ABORT, RETRY, WAIT_SYNC).
- Arithmetic:
  - Timers saturate rather than wrap (unreachable given the comparisons).
  - retry_cnt is 2 bits; MAX_RETRY ≤ 3.
- Spurious inputs: got_sync, pkt_done, EOP_error outside their listening state are ignored.

Test Plan:
- Happy DATA path: start, kind=0; got_sync at cycle 5; pkt_done=1, pkt_ok=1 at cycle 40 → receive_data high cycles 1–40, done at cycle 41 with status=00, retry_cnt=0, abort never asserted.
- Sync timeout with retries (TO_CYCLES=10, MAX_RETRY=3, no got_sync) → 4 abort pulses and 3 retry pulses; done with status=01, retry_cnt=3; busy low the cycle after done.
- CRC fail then recovery: first attempt pkt_done with pkt_ok=0; second attempt pkt_ok=1 → one abort, one retry, final status=00, retry_cnt=1.
- Collisions: EOP_error and pkt_done&pkt_ok in the same cycle → ABORT (cause EOP). got_sync on the timeout cycle → RECV, no abort.
- Handshake with reset: start with kind=1 → receive_hshake only. Assert rst mid-RECV → all outputs 0 immediately, no done; new start after release works normally.
- start while busy: pulse start during WAIT_SYNC with the opposite kind → ignored; kind unchanged.

Source files
------------

// File: rtl/rc_pkt_sequencer.sv
// Receive-side transaction sequencer for the rc_dpdm decoder: arms the decoder,
// polices SYNC/packet watchdogs, aborts on failure and requests bounded retries.
module rc_pkt_sequencer #(
  parameter int TO_CYCLES  = 255,
  parameter int PKT_CYCLES = 255,
  parameter int MAX_RETRY  = 3,
  parameter int TW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       kind,
  input  logic       got_sync,
  input  logic       EOP_error,
  input  logic       pkt_done,
  input  logic       pkt_ok,
  output logic       receive_data,
  output logic       receive_hshake,
  output logic       abort,
  output logic       retry,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [1:0] retry_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_ABORT = 3'd3;
  localparam logic [2:0] S_RETRY = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_EOP = 2'b10;
  localparam logic [1:0] ST_CRC = 2'b11;

  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
  localparam logic [TW-1:0] PKT_LAST  = TW'(PKT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  // Watchdog timers hold at all-ones instead of wrapping back to zero.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [2:0]    state_q, state_d;
  logic          kind_q, kind_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    retry_cnt_q, retry_cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [1:0]    status_q, status_d;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    cause_d     = cause_q;
    status_d    = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kind_d      = kind;
          timer_d     = '0;
          retry_cnt_d = 2'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (got_sync) begin
          timer_d = '0;
          state_d = S_RECV;
        end else if (timer_q == TO_LAST) begin
          cause_d = ST_TO;
          state_d = S_ABORT;
        end else begin
          timer_d = sat_inc(timer_q);
        end
      end
      S_RECV: begin
        if (EOP_error) begin
          cause_d = ST_EOP;
          state_d = S_ABORT;
        end else if (pkt_done && pkt_ok) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (pkt_done) begin
          cause_d = ST_CRC;
          state_d = S_ABORT;
        end else if (timer_q == PKT_LAST) begin
          cause_d = ST_TO;
          state_d = S_ABORT;
        end else begin
          timer_d = sat_inc(timer_q);
        end
      end
      S_ABORT: begin
        if (retry_cnt_q < RETRY_MAX) begin
          state_d = S_RETRY;
        end else begin
          status_d = cause_q;
          state_d  = S_DONE;
        end
      end
      S_RETRY: begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        timer_d     = '0;
        state_d     = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status is loaded on entry to DONE so it is already valid alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= 1'b0;
      timer_q     <= '0;
      retry_cnt_q <= 2'd0;
      cause_q     <= ST_OK;
      status_q    <= ST_OK;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      cause_q     <= cause_d;
      status_q    <= status_d;
    end
  end

  logic armed;
  assign armed          = (state_q == S_WAIT) || (state_q == S_RECV);
  assign receive_data   = armed & ~kind_q;
  assign receive_hshake = armed & kind_q;
  assign abort          = (state_q == S_ABORT);
  assign retry          = (state_q == S_RETRY);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign status         = status_q;
  assign retry_cnt      = retry_cnt_q;

endmodule
